// File: rtl/gf_div_mds_if.sv
// gf_div_mds_if: operand/result handshake bundle for the GF(2^8) divider.
// master = operand producer / result consumer, slave = divider.
interface gf_div_mds_if;
    localparam int unsigned DATA_W = 8;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] num;
    logic [DATA_W-1:0] den;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] quot;
    logic              div_zero;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quot, div_zero
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quot, div_zero
    );
endinterface

// File: rtl/gf_div_mds.sv
// gf_div_mds: sequential divider over GF(2^8) mod x^8+x^6+x^5+x^3+1 (0x169).
// quot = num * den^254 via square-and-multiply; one operation in flight.
// Optional macro GF_DIV_UNIT_BYPASS_EN: den==0x01 completes in one edge.
module gf_div_mds #(
    parameter int unsigned INV_STEPS = 7
) (
    input  logic           clk,
    input  logic           rst,
    gf_div_mds_if.slave    bus
);
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam logic [DATA_W-1:0] POLY_LO = 8'h69;

    typedef enum logic [1:0] {IDLE, INV, MUL, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] a_r, a_nxt;
    logic [DATA_W-1:0] s_r, s_nxt;
    logic [DATA_W-1:0] acc_r, acc_nxt;
    logic [DATA_W-1:0] quot_r, quot_nxt;
    logic              div_zero_r, div_zero_nxt;
    logic              in_ready_r, out_valid_r;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] s_sq_c;

    // Shift-and-add multiply, MSB first, reducing by 0x169 at each doubling.
    function automatic logic [DATA_W-1:0] gf_mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] p;
        p = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            p = {p[DATA_W-2:0], 1'b0} ^ (p[DATA_W-1] ? POLY_LO : 8'h00)
                ^ (b[i] ? a : 8'h00);
        end
        return p;
    endfunction

    // Squared base shared by the s and acc updates.
    assign s_sq_c = gf_mul(s_r, s_r);

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quot      = quot_r;
    assign bus.div_zero  = div_zero_r;

    // Next-state and datapath update.
    always_comb begin
        state_nxt    = state;
        a_nxt        = a_r;
        s_nxt        = s_r;
        acc_nxt      = acc_r;
        cnt_nxt      = cnt;
        quot_nxt     = quot_r;
        div_zero_nxt = div_zero_r;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    a_nxt   = bus.num;
                    s_nxt   = bus.den;
                    acc_nxt = 8'h01;
                    cnt_nxt = '0;
                    if (bus.den == 8'h00) begin
                        quot_nxt     = 8'h00;
                        div_zero_nxt = 1'b1;
                        state_nxt    = DONE;
`ifdef GF_DIV_UNIT_BYPASS_EN
                    end else if (bus.den == 8'h01) begin
                        quot_nxt     = bus.num;
                        div_zero_nxt = 1'b0;
                        state_nxt    = DONE;
`endif
                    end else begin
                        state_nxt = INV;
                    end
                end
            end
            INV: begin
                s_nxt   = s_sq_c;
                acc_nxt = gf_mul(acc_r, s_sq_c);
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(INV_STEPS - 1)) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                quot_nxt     = gf_mul(a_r, acc_r);
                div_zero_nxt = 1'b0;
                state_nxt    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            s_r         <= '0;
            acc_r       <= '0;
            cnt         <= '0;
            quot_r      <= '0;
            div_zero_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state       <= state_nxt;
            a_r         <= a_nxt;
            s_r         <= s_nxt;
            acc_r       <= acc_nxt;
            cnt         <= cnt_nxt;
            quot_r      <= quot_nxt;
            div_zero_r  <= div_zero_nxt;
            in_ready_r  <= (state_nxt == IDLE);
            out_valid_r <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_gf_div_mds.sv
// tb_gf_div_mds: directed and randomized checks of gf_div_mds against a
// polynomial-division reference model with brute-force inversion.
module tb_gf_div_mds;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gf_div_mds_if bus ();

    gf_div_mds dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full carry-less product, then long division by 0x169.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h0169 << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] d);
        for (int x = 1; x < 256; x++) begin
            if (ref_mul(d, 8'(x)) == 8'h01) return 8'(x);
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_quot(input logic [7:0] n, input logic [7:0] d);
        if (d == 8'h00) return 8'h00;
        return ref_mul(n, ref_inv(d));
    endfunction

    function automatic int exp_lat(input logic [7:0] d);
        if (d == 8'h00) return 1;
`ifdef GF_DIV_UNIT_BYPASS_EN
        if (d == 8'h01) return 1;
`endif
        return 9;
    endfunction

    // Present operands and return #1 after the accept edge.
    task automatic start_op(input logic [7:0] n, input logic [7:0] d);
        @(negedge clk);
        bus.num      = n;
        bus.den      = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.num      = 8'($urandom);
        bus.den      = 8'($urandom);
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_result(input logic [7:0] eq, input logic edz, input int elat);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", 32'(bus.out_valid), 32'd1);
        check("latency", 32'(lat), 32'(elat));
        check("quot", 32'(bus.quot), 32'(eq));
        check("div_zero", 32'(bus.div_zero), 32'(edz));
    endtask

    // Hold backpressure for some cycles, then complete the result handshake.
    task automatic finish_op(input logic [7:0] eq, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_quot", 32'(bus.quot), 32'(eq));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] n, input logic [7:0] d,
                          input logic [7:0] eq, input logic edz, input int hold);
        start_op(n, d);
        wait_result(eq, edz, exp_lat(d));
        finish_op(eq, hold);
    endtask

    initial begin
        logic [7:0] n;
        logic [7:0] d;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num       = 8'h00;
        bus.den       = 8'h00;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_quot", 32'(bus.quot), 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived results.
        run_op(8'h01, 8'h02, 8'hB4, 1'b0, 0);
        run_op(8'hB6, 8'h5B, 8'h02, 1'b0, 0);
        run_op(8'h5B, 8'h5B, 8'h01, 1'b0, 0);
        run_op(8'h37, 8'h00, 8'h00, 1'b1, 0);
        run_op(8'h00, 8'h37, 8'h00, 1'b0, 0);
        run_op(8'h9C, 8'h01, 8'h9C, 1'b0, 0);

        // Backpressure with a competing in_valid that must be ignored.
        start_op(8'hB6, 8'h5B);
        wait_result(8'h02, 1'b0, 9);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.num      = 8'h5B;
        bus.den      = 8'h5B;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_quot", 32'(bus.quot), 32'h02);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_hs_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_accept", 32'(bus.in_ready), 32'd0);
        wait_result(8'h01, 1'b0, 9);
        finish_op(8'h01, 0);

        // Reset in the third INV cycle aborts the operation.
        start_op(8'h01, 8'h02);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_quot", 32'(bus.quot), 32'd0);
        check("abort_div_zero", 32'(bus.div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("abort_no_result", 32'(bus.out_valid), 32'd0);
        end
        run_op(8'h01, 8'h02, 8'hB4, 1'b0, 0);

        // Randomized operands, occasional zero/unit divisor, random backpressure.
        for (int k = 0; k < 40; k++) begin
            n = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       d = 8'h00;
                1:       d = 8'h01;
                default: d = 8'($urandom);
            endcase
            run_op(n, d, ref_quot(n, d), (d == 8'h00), int'($urandom_range(0, 3)));
        end

        // Sweep every nonzero divisor with num=1: result must be den^-1.
        for (int k = 1; k < 256; k++) begin
            d = 8'(k);
            start_op(8'h01, d);
            wait_result(ref_inv(d), 1'b0, exp_lat(d));
            check("inv_product", 32'(ref_mul(bus.quot, d)), 32'h01);
            finish_op(ref_inv(d), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gf_div_mds.md
Name: gf_div_mds

Overview:
- Sequential GF(2^8) divider over the Twofish MDS field polynomial x^8+x^6+x^5+x^3+1 (0x169). This is the same field used by the constant multipliers (x5B, xEF) in the MDS/key-schedule path.
- Computes quot = num * den^-1.
- The inverse is formed by square-and-multiply as den^254.
- Serves decrypt-side and key-schedule verification logic that must undo an MDS-field multiply.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- INV_STEPS, 7, number of square-and-multiply iterations; fixed for 254 = 2+4+...+128; any other value is illegal.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- num  input  8  dividend (GF element)
- den  input  8  divisor (GF element)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quot  output  8  quotient num/den
- div_zero  output  1  den was 0x00; quot forced to 0x00

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, quot=0x00, div_zero=0, internal regs cleared. A reset during any state aborts the operation; no result is produced.
- States: IDLE, INV, MUL, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept edge: in_valid && in_ready. Latch num into a_r and den into s_r; set acc_r=0x01 and cnt=0.
  - If den==0x00: go to DONE with quot=0x00, div_zero=1 (latency 1).
  - Else: go to INV.
- INV, each cycle:
  - s_r <= s_r^2.
  - acc_r <= acc_r * (s_r^2), both combinational GF multiplies with reduction by 0x169.
  - cnt++.
  - After INV_STEPS cycles (cnt==6 on the last), go to MUL. acc_r then equals den^254 = den^-1.
- MUL: one cycle; quot <= a_r * acc_r, div_zero <= 0; go to DONE.
- Nominal latency: accept edge to out_valid high = 9 edges (1 load + 7 INV + 1 MUL).
- DONE: quot and div_zero held stable while out_valid=1 && out_ready=0. On the edge with out_ready=1, go to IDLE.
- in_valid is ignored when not IDLE. num/den may change freely after the accept edge without affecting the result.
- Same edge as a DONE handshake: in_ready is still 0, so a new operand is accepted no earlier than the following cycle. Throughput is 1 op per ≥10 cycles.
- GF multiply: carry-less 8x8 product reduced modulo 0x169. All arithmetic is XOR-only; no integer carries.
- Special values: den==0x01 gives quot==num; num==0x00 with nonzero den gives quot==0x00, div_zero=0.

Optional Feature:
- Macro GF_DIV_UNIT_BYPASS_EN.
- Defined: at the accept edge, den==0x01 goes directly to DONE with quot=num and div_zero=0 (latency 1, same as the zero-divisor path). All other values behave as nominal.
- Undefined: den==0x01 takes the full 9-cycle path with an identical result.
- Result values never differ between builds; only latency differs.

Test Plan:
- Reset then num=0x01, den=0x02, in_valid pulse → out_valid exactly 9 edges after accept, quot=0xB4, div_zero=0.
- num=0xB6, den=0x5B → quot=0x02. num=0x5B, den=0x5B → quot=0x01.
- num=0x37, den=0x00 → out_valid 1 edge after accept, quot=0x00, div_zero=1. num=0x00, den=0x37 → quot=0x00, div_zero=0 after 9 edges.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → quot stable and in_ready=0 throughout; new in_valid ignored until the handshake completes, then accepted the next cycle.
- Assert rst mid-INV (3rd cycle) → outputs return to reset values immediately. The next op, num=0x01/den=0x02, yields 0xB4 normally.
- num=0x9C, den=0x01 → quot=0x9C.
  - With GF_DIV_UNIT_BYPASS_EN: latency 1.
  - Without it: latency 9.
  - Exhaustive sweep of den 0x01..0xFF with num=0x01: quot*den==0x01 in a reference model.
